// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared constants and helpers for the parametrised UART receiver.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Parity modes
    localparam int c_PAR_NONE = 0;
    localparam int c_PAR_EVEN = 1;
    localparam int c_PAR_ODD  = 2;

    // Parity bit a transmitter should have sent for this word; unused bits must be zero.
    function automatic logic parity_expected(input int mode, input logic [8:0] data);
        logic p;
        p = ^data;
        if (mode == c_PAR_ODD)
            return ~p;
        else if (mode == c_PAR_EVEN)
            return p;
        else
            return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_sampler
// Brief  : 2-flop line synchroniser plus 3-tap mid-bit majority vote.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int TC_W       = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            rxDataIn,
    input  logic [TC_W-1:0] tc,
    output logic            line_sync,
    output logic            bit_val,
    output logic            bit_strobe
);

    localparam int              c_M    = OVERSAMPLE / 2;
    localparam logic [TC_W-1:0] c_TC_A = TC_W'(c_M - 1);
    localparam logic [TC_W-1:0] c_TC_B = TC_W'(c_M);
    localparam logic [TC_W-1:0] c_TC_C = TC_W'(c_M + 1);

    logic r_meta;
    logic r_sync;
    logic r_vote_a;
    logic r_vote_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_vote_a <= 1'b1;
            r_vote_b <= 1'b1;
        end else begin
            r_meta <= rxDataIn;
            r_sync <= r_meta;
            if (enable && (tc == c_TC_A))
                r_vote_a <= r_sync;
            if (enable && (tc == c_TC_B))
                r_vote_b <= r_sync;
        end
    end

    // Third tap is the live synchronised line at the decision tick.
    assign line_sync  = r_sync;
    assign bit_strobe = enable && (tc == c_TC_C);
    assign bit_val    = (r_vote_a & r_vote_b) | (r_vote_a & r_sync) | (r_vote_b & r_sync);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_param
// Brief  : Parametrised UART receive engine with valid/ready holding register.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rxDataIn,
    output logic [DATA_BITS-1:0] rxDataOut,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                c_TC_W     = $clog2(OVERSAMPLE);
    localparam int                c_BC_W     = $clog2(DATA_BITS);
    localparam logic [c_TC_W-1:0] c_TC_LAST  = c_TC_W'(OVERSAMPLE - 1);
    localparam logic [c_BC_W-1:0] c_BIT_LAST = c_BC_W'(DATA_BITS - 1);
    localparam logic              c_STOP_LAST = 1'(STOP_BITS - 1);

    logic [2:0]           r_state;
    logic [c_TC_W-1:0]    r_tc;
    logic [c_BC_W-1:0]    r_bitcnt;
    logic                 r_stopcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_armed;

    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid;
    logic                 r_perr_out;
    logic                 r_ferr_out;
    logic                 r_overrun;

    logic w_line;
    logic w_bit;
    logic w_strobe;
    logic w_tc_wrap;
    logic w_last_stop;
    logic w_done;
    logic w_ferr_now;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .TC_W       (c_TC_W)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rxDataIn   (rxDataIn),
        .tc         (r_tc),
        .line_sync  (w_line),
        .bit_val    (w_bit),
        .bit_strobe (w_strobe)
    );

    assign w_tc_wrap   = (r_tc == c_TC_LAST);
    assign w_last_stop = (r_stopcnt == c_STOP_LAST);
    assign w_done      = w_strobe && (r_state == c_ST_STOP) && w_last_stop;
    assign w_ferr_now  = r_frame_err | ~w_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_tc        <= '0;
            r_bitcnt    <= '0;
            r_stopcnt   <= 1'b0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_armed     <= 1'b0;
        end else if (enable) begin
            if (r_state == c_ST_IDLE) begin
                r_tc <= '0;
                if (w_line)
                    r_armed <= 1'b1;
                else if (r_armed) begin
                    r_state     <= c_ST_START;
                    r_par_err   <= 1'b0;
                    r_frame_err <= 1'b0;
                end
            end else begin
                r_tc <= w_tc_wrap ? '0 : r_tc + c_TC_W'(1);
                case (r_state)
                    c_ST_START: begin
                        if (w_strobe && w_bit) begin
                            r_state <= c_ST_IDLE;
                            r_tc    <= '0;
                        end else if (w_tc_wrap) begin
                            r_state  <= c_ST_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    c_ST_DATA: begin
                        if (w_strobe)
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        if (w_tc_wrap) begin
                            if (r_bitcnt == c_BIT_LAST) begin
                                r_state   <= (PARITY_MODE == c_PAR_NONE) ? c_ST_STOP : c_ST_PARITY;
                                r_stopcnt <= 1'b0;
                            end else begin
                                r_bitcnt <= r_bitcnt + c_BC_W'(1);
                            end
                        end
                    end
                    c_ST_PARITY: begin
                        if (w_strobe)
                            r_par_err <= (w_bit != parity_expected(PARITY_MODE, 9'(r_shift)));
                        if (w_tc_wrap) begin
                            r_state   <= c_ST_STOP;
                            r_stopcnt <= 1'b0;
                        end
                    end
                    c_ST_STOP: begin
                        if (w_strobe && !w_bit)
                            r_frame_err <= 1'b1;
                        // Final stop bit completes the frame at its decision tick.
                        if (w_done) begin
                            r_state <= c_ST_IDLE;
                            r_tc    <= '0;
                            r_armed <= 1'b0;
                        end else if (w_tc_wrap) begin
                            r_stopcnt <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_tc    <= '0;
                    end
                endcase
            end
        end
    end

    // Holding register: a completed frame is dropped only if the held word is not leaving.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_done && (!r_valid || rxReady)) begin
            r_data_out <= r_shift;
            r_valid    <= 1'b1;
            r_perr_out <= r_par_err;
            r_ferr_out <= w_ferr_now;
            r_overrun  <= 1'b0;
        end else if (w_done) begin
            r_overrun <= 1'b1;
        end else if (r_valid && rxReady) begin
            r_valid <= 1'b0;
        end
    end

    assign rxDataOut = r_data_out;
    assign rxValid   = r_valid;
    assign parityErr = r_perr_out;
    assign frameErr  = r_ferr_out;
    assign overrun   = r_overrun;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
